i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter HOLD_MAX, default 1000: idle-owner watchdog limit in clock cycles (16-bit counter).
REQ-003 clock  in  1  system clock; all state changes on the posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req  in  2  per-requester bus request, level, held for the whole transaction.
REQ-006 gnt  out  2  one-hot grant; 0 means no owner.
REQ-007 r_start, r_stop, r_rw, r_go  in  2 each  per-requester command bits; r_go is a 1-cycle pulse.
REQ-008 r_data_w  in  16  requester n byte in bits [8n+7:8n].
REQ-009 r_ack, r_ack_r, r_nack, r_timeout  out  2 each  per-requester response pulses.
REQ-010 r_data_r  out  8  read byte, valid on the cycle r_ack_r is set.
REQ-011 m_start, m_stop, m_rw, m_go  out  1 each  command to the I2C master; m_go is a 1-cycle pulse.
REQ-012 m_data_w  out  8  byte to the I2C master.
REQ-013 m_ack, m_ack_r, m_nack, m_timeout, m_busy  in  1 each  I2C master status.
REQ-014 m_data_r  in  8  I2C master read byte.

Function
REQ-015 States SHALL be IDLE, OWNED, BUSY, ABANDON and RELEASE.
REQ-016 IDLE: when any req bit is 1, the block SHALL assert the winner's gnt on the next cycle and go to OWNED.
REQ-017 OWNED: the owner's r_go SHALL be registered to m_go with m_start/m_stop/m_rw/m_data_w one cycle later (1-cycle latency); the block SHALL then enter BUSY.
REQ-018 r_go from a non-owner, or in any state other than OWNED, SHALL be ignored.
REQ-019 BUSY: the first m_ack/m_ack_r/m_nack/m_timeout pulse SHALL be routed to the owner's r_* bit one cycle later, with m_data_r registered to r_data_r.
REQ-020 After BUSY: nack, timeout, or a command issued with stop=1 SHALL lead to RELEASE; otherwise the block SHALL return to OWNED.
REQ-021 RELEASE: wait until m_busy=0, then clear gnt, update the priority pointer and return to IDLE.
REQ-022 Owner dropping req in OWNED with no open transaction (no start issued since grant, or last command had stop) SHALL lead directly to RELEASE.
REQ-023 Owner dropping req in OWNED with an open transaction SHALL lead to ABANDON.
REQ-024 ABANDON: the block SHALL issue its own m_go with m_start=0, m_stop=1 and m_data_w=0, wait for a response, route no response to any requester, then go to RELEASE.
REQ-025 Watchdog: the counter SHALL clear on every owner r_go.
REQ-026 Watchdog: in OWNED with no r_go for HOLD_MAX cycles, the block SHALL behave as if req had dropped.
REQ-027 A req drop during BUSY SHALL be acted on after the response, in OWNED.
REQ-028 If a response pulse and an owner r_go coincide, the response SHALL be handled first and the r_go ignored.
REQ-029 At most one m_go SHALL be outstanding; m_go SHALL never be asserted while in BUSY.

Reset
REQ-030 Reset SHALL take the state to IDLE.
REQ-031 Reset SHALL clear gnt, all r_* outputs, all m_* outputs, r_data_r, the watchdog counter and the priority pointer (requester 0 first), from any state including BUSY.

Configuration
REQ-032 Macro I2C_ARB_RR_EN defined: round-robin; after a release the other requester has priority on simultaneous requests.
REQ-033 Macro I2C_ARB_RR_EN undefined: fixed priority, requester 0 always wins; the pointer is unused.

Verification
REQ-034 req=01, r_go0 with start=1 and data 0xA0 -> gnt=01 next cycle; m_go pulses 1 cycle after r_go0 with m_data_w=0xA0; m_ack routed to r_ack=01.
REQ-035 Simultaneous req=11 after reset -> gnt=01; after requester 0's stop transaction and m_busy=0 -> gnt=10 (RR); with the macro undefined and req0 still high -> gnt=01 again.
REQ-036 Owner 1 read with m_ack_r and m_data_r=0x5C -> r_ack_r=10 and r_data_r=0x5C on the same cycle; r_ack_r[0] stays 0.
REQ-037 Owner 0 drops req after a start command is acked -> m_go with m_stop=1; response not routed; gnt=00 once m_busy=0.
REQ-038 HOLD_MAX=8 and the owner idles 8 cycles with no transaction -> gnt cleared; m_nack during BUSY -> RELEASE, no further m_go.
REQ-039 Reset asserted in BUSY -> next cycle gnt=00, m_go=0, state IDLE; a later m_ack is not routed.

Source files
------------

// File: rtl/i2c_arbiter.sv
// Two-requester arbiter sharing one I2C master; grants, forwards commands (1-cycle) and routes responses back (1-cycle).
// Priority: fixed (requester 0 wins) by default, round-robin when I2C_ARB_RR_EN is defined.
module i2c_arbiter #(
    parameter int HOLD_MAX = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  r_start,
    input  logic [1:0]  r_stop,
    input  logic [1:0]  r_rw,
    input  logic [1:0]  r_go,
    input  logic [15:0] r_data_w,
    output logic [1:0]  r_ack,
    output logic [1:0]  r_ack_r,
    output logic [1:0]  r_nack,
    output logic [1:0]  r_timeout,
    output logic [7:0]  r_data_r,
    output logic        m_start,
    output logic        m_stop,
    output logic        m_rw,
    output logic        m_go,
    output logic [7:0]  m_data_w,
    input  logic        m_ack,
    input  logic        m_ack_r,
    input  logic        m_nack,
    input  logic        m_timeout,
    input  logic        m_busy,
    input  logic [7:0]  m_data_r
);
    typedef enum logic [2:0] {IDLE, OWNED, BUSY, ABANDON, RELEASE} state_t;

    localparam logic [15:0] WD_LIMIT = 16'(HOLD_MAX - 1);

    state_t      state, state_n;
    logic [1:0]  gnt_n;
    logic [15:0] wd_cnt, wd_cnt_n;
    logic        open_txn, open_txn_n;
    logic        last_stop, last_stop_n;
    logic        go_vld, go_start, go_stop, go_rw;
    logic [7:0]  go_dat;
    logic        route;
    logic        owner, owner_go, owner_req, resp, wd_expired, win;

    assign owner      = gnt[1];
    assign owner_go   = |(r_go & gnt);
    assign owner_req  = |(req & gnt);
    assign resp       = m_ack | m_ack_r | m_nack | m_timeout;
    assign wd_expired = (wd_cnt >= WD_LIMIT);

`ifdef I2C_ARB_RR_EN
    // ptr names the requester that wins a tie; it flips away from whoever just released.
    logic ptr;
    logic rel_done;
    assign rel_done = (state == RELEASE) && !m_busy;
    assign win      = req[1] & (~req[0] | ptr);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (rel_done) begin
            ptr <= ~owner;
        end
    end
`else
    assign win = ~req[0];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        wd_cnt_n    = wd_cnt;
        open_txn_n  = open_txn;
        last_stop_n = last_stop;
        go_vld      = 1'b0;
        go_start    = m_start;
        go_stop     = m_stop;
        go_rw       = m_rw;
        go_dat      = m_data_w;
        route       = 1'b0;
        case (state)
            IDLE: begin
                wd_cnt_n    = '0;
                open_txn_n  = 1'b0;
                last_stop_n = 1'b0;
                if (|req) begin
                    gnt_n   = win ? 2'b10 : 2'b01;
                    state_n = OWNED;
                end
            end
            OWNED: begin
                if (owner_go) begin
                    go_vld      = 1'b1;
                    go_start    = r_start[owner];
                    go_stop     = r_stop[owner];
                    go_rw       = r_rw[owner];
                    go_dat      = owner ? r_data_w[15:8] : r_data_w[7:0];
                    last_stop_n = r_stop[owner];
                    if (r_stop[owner]) begin
                        open_txn_n = 1'b0;
                    end else if (r_start[owner]) begin
                        open_txn_n = 1'b1;
                    end
                    wd_cnt_n = '0;
                    state_n  = BUSY;
                end else if (!owner_req || wd_expired) begin
                    wd_cnt_n = '0;
                    if (open_txn) begin
                        // Close the half-open bus transaction on the owner's behalf.
                        go_vld     = 1'b1;
                        go_start   = 1'b0;
                        go_stop    = 1'b1;
                        go_rw      = 1'b0;
                        go_dat     = '0;
                        open_txn_n = 1'b0;
                        state_n    = ABANDON;
                    end else begin
                        state_n = RELEASE;
                    end
                end else begin
                    wd_cnt_n = wd_cnt + 16'd1;
                end
            end
            BUSY: begin
                if (resp) begin
                    route   = 1'b1;
                    state_n = (m_nack || m_timeout || last_stop) ? RELEASE : OWNED;
                end
            end
            ABANDON: begin
                if (resp) begin
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!m_busy) begin
                    gnt_n   = 2'b00;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt       <= '0;
            wd_cnt    <= '0;
            open_txn  <= 1'b0;
            last_stop <= 1'b0;
            m_go      <= 1'b0;
            m_start   <= 1'b0;
            m_stop    <= 1'b0;
            m_rw      <= 1'b0;
            m_data_w  <= '0;
            r_ack     <= '0;
            r_ack_r   <= '0;
            r_nack    <= '0;
            r_timeout <= '0;
            r_data_r  <= '0;
        end else begin
            gnt       <= gnt_n;
            wd_cnt    <= wd_cnt_n;
            open_txn  <= open_txn_n;
            last_stop <= last_stop_n;
            m_go      <= go_vld;
            m_start   <= go_start;
            m_stop    <= go_stop;
            m_rw      <= go_rw;
            m_data_w  <= go_dat;
            r_ack     <= (route && m_ack)     ? gnt : 2'b00;
            r_ack_r   <= (route && m_ack_r)   ? gnt : 2'b00;
            r_nack    <= (route && m_nack)    ? gnt : 2'b00;
            r_timeout <= (route && m_timeout) ? gnt : 2'b00;
            if (route) begin
                r_data_r <= m_data_r;
            end
        end
    end
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed and randomized bench for i2c_arbiter (HOLD_MAX=8); expectations come from the arbitration rules.
module tb_i2c_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req, gnt, r_start, r_stop, r_rw, r_go;
    logic [1:0]  r_ack, r_ack_r, r_nack, r_timeout;
    logic [15:0] r_data_w;
    logic [7:0]  r_data_r, m_data_w, m_data_r;
    logic        m_start, m_stop, m_rw, m_go;
    logic        m_ack, m_ack_r, m_nack, m_timeout, m_busy;

    int n_pass  = 0;
    int n_total = 0;
    int rr_ptr  = 0;

    always #5 clock = ~clock;

    i2c_arbiter #(.HOLD_MAX(8)) dut (
        .clock(clock), .reset(reset), .req(req), .gnt(gnt),
        .r_start(r_start), .r_stop(r_stop), .r_rw(r_rw), .r_go(r_go),
        .r_data_w(r_data_w), .r_ack(r_ack), .r_ack_r(r_ack_r),
        .r_nack(r_nack), .r_timeout(r_timeout), .r_data_r(r_data_r),
        .m_start(m_start), .m_stop(m_stop), .m_rw(m_rw), .m_go(m_go),
        .m_data_w(m_data_w), .m_ack(m_ack), .m_ack_r(m_ack_r),
        .m_nack(m_nack), .m_timeout(m_timeout), .m_busy(m_busy),
        .m_data_r(m_data_r)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; r_start = '0; r_stop = '0; r_rw = '0; r_go = '0;
        r_data_w = '0; m_ack = 0; m_ack_r = 0; m_nack = 0; m_timeout = 0;
        m_busy = 0; m_data_r = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_gnt(input bit want_zero, input string tag);
        int k = 0;
        while (((gnt == 2'b00) != want_zero) && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < 20), 32'd1);
    endtask

    // Pulse requester n's r_go; a forwarded command must appear on m_* one cycle later.
    task automatic issue(input int n, input bit st, input bit sp, input bit rw,
                         input logic [7:0] d, input bit exp_go);
        r_go = '0; r_start = '0; r_stop = '0; r_rw = '0;
        r_go[n] = 1'b1; r_start[n] = st; r_stop[n] = sp; r_rw[n] = rw;
        r_data_w[8*n +: 8] = d;
        tick();
        r_go = '0;
        chk("m_go", 32'(m_go), 32'(exp_go));
        if (exp_go) begin
            chk("m_cmd", {20'd0, m_start, m_stop, m_rw, 1'b0, m_data_w}, {20'd0, st, sp, rw, 1'b0, d});
            m_busy = 1'b1;
        end
        tick();
        chk("m_go_pulse", 32'(m_go), 32'd0);
    endtask

    // kind: 0 ack, 1 ack_r, 2 nack, 3 timeout
    task automatic respond(input int kind, input logic [7:0] d, input logic [1:0] mask);
        logic [7:0] e;
        e = '0;
        m_ack = (kind == 0); m_ack_r = (kind == 1); m_nack = (kind == 2); m_timeout = (kind == 3);
        m_data_r = d;
        tick();
        m_ack = 0; m_ack_r = 0; m_nack = 0; m_timeout = 0;
        case (kind)
            0: e[7:6] = mask;
            1: e[5:4] = mask;
            2: e[3:2] = mask;
            default: e[1:0] = mask;
        endcase
        chk("route", 32'({r_ack, r_ack_r, r_nack, r_timeout}), 32'(e));
        if (kind == 1 && mask != 2'b00) chk("r_data_r", 32'(r_data_r), 32'(d));
        tick();
        chk("route_pulse", 32'({r_ack, r_ack_r, r_nack, r_timeout}), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "bench stopped");
    end

    initial begin
        logic [1:0] rq;
        int w, nb, kind, k;
        bit done, last;

        do_reset();
        chk("reset_outs", 32'({gnt, m_go, m_start, m_stop, r_ack, r_ack_r, r_nack, r_timeout}), 32'd0);
        chk("reset_data", 32'({m_data_w, r_data_r}), 32'd0);

        // Simultaneous request after reset; basic write flow and non-owner r_go.
        req = 2'b11;
        tick();
        chk("gnt_first", 32'(gnt), 32'd1);
        issue(1, 1, 0, 0, 8'hEE, 0);
        issue(0, 1, 0, 0, 8'hA0, 1);
        respond(0, 8'h00, 2'b01);
        issue(0, 0, 1, 0, 8'h55, 1);
        respond(0, 8'h00, 2'b01);
        tick();
        chk("hold_while_busy", 32'(gnt), 32'd1);
        m_busy = 1'b0;
        wait_gnt(1, "release_wait");
        wait_gnt(0, "regrant_wait");
`ifdef I2C_ARB_RR_EN
        chk("regrant_rr", 32'(gnt), 32'd2);
`else
        chk("regrant_fixed", 32'(gnt), 32'd1);
`endif

        // Owner 1 read.
        do_reset();
        req = 2'b10;
        tick();
        chk("gnt_owner1", 32'(gnt), 32'd2);
        issue(1, 1, 1, 1, 8'hA1, 1);
        respond(1, 8'h5C, 2'b10);
        m_busy = 1'b0;
        wait_gnt(1, "read_release");

        // Owner drops req with an open transaction.
        do_reset();
        req = 2'b01;
        tick();
        issue(0, 1, 0, 0, 8'h3C, 1);
        respond(0, 8'h00, 2'b01);
        req = 2'b00;
        tick();
        chk("abandon_go", 32'(m_go), 32'd1);
        chk("abandon_cmd", {22'd0, m_start, m_stop, m_data_w}, {22'd0, 1'b0, 1'b1, 8'h00});
        tick();
        chk("abandon_pulse", 32'(m_go), 32'd0);
        respond(0, 8'h00, 2'b00);
        tick();
        chk("abandon_hold", 32'(gnt), 32'd1);
        m_busy = 1'b0;
        wait_gnt(1, "abandon_release");

        // Watchdog, then nack-driven release with r_go ignored during RELEASE.
        do_reset();
        req = 2'b01;
        tick();
        chk("wd_gnt", 32'(gnt), 32'd1);
        repeat (6) tick();
        chk("wd_still_owned", 32'(gnt), 32'd1);
        k = 0;
        while (gnt != 2'b00 && k < 10) begin
            tick();
            k++;
        end
        chk("wd_release", 32'(k >= 2 && k <= 4), 32'd1);
        wait_gnt(0, "wd_regrant");
        issue(0, 1, 0, 0, 8'h11, 1);
        respond(2, 8'h00, 2'b01);
        issue(0, 1, 0, 0, 8'h22, 0);
        m_busy = 1'b0;
        wait_gnt(1, "nack_release");

        // Reset while BUSY.
        do_reset();
        req = 2'b01;
        tick();
        issue(0, 1, 0, 0, 8'h77, 1);
        reset = 1'b1;
        req = 2'b00;
        tick();
        reset = 1'b0;
        m_busy = 1'b0;
        chk("busy_reset", 32'({gnt, m_go}), 32'd0);
        respond(0, 8'h00, 2'b00);
        chk("busy_reset_gnt", 32'(gnt), 32'd0);

        // Randomized transactions against the arbitration rules.
        do_reset();
        rr_ptr = 0;
        for (int t = 0; t < 40; t++) begin
            rq = 2'($urandom_range(1, 3));
`ifdef I2C_ARB_RR_EN
            w = (rq == 2'b11) ? rr_ptr : ((rq == 2'b10) ? 1 : 0);
`else
            w = rq[0] ? 0 : 1;
`endif
            req = rq;
            wait_gnt(0, "rnd_gnt_wait");
            chk("rnd_gnt", 32'(gnt), 32'(1 << w));
            nb = $urandom_range(1, 3);
            done = 0;
            for (int b = 0; b < nb && !done; b++) begin
                repeat ($urandom_range(0, 3)) tick();
                last = (b == nb - 1);
                issue(w, b == 0, last, 1'($urandom_range(0, 1)), 8'($urandom), 1);
                if ($urandom_range(0, 1) == 1) begin
                    r_go[w] = 1'b1;
                    tick();
                    r_go = '0;
                    chk("rnd_busy_go", 32'(m_go), 32'd0);
                end
                kind = $urandom_range(0, 3);
                respond(kind, 8'($urandom), 2'(1 << w));
                if (last || kind >= 2) done = 1;
            end
            repeat ($urandom_range(0, 2)) tick();
            m_busy = 1'b0;
            wait_gnt(1, "rnd_release");
            rr_ptr = 1 - w;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
